// File: rtl/xtea_crypt_core_if.sv
// Bus bundle between the cipher wrapper and the XTEA engine.
//   i_flag    direction for the block being started (1 = encrypt, 0 = decrypt)
//   i_key     128-bit key, K0 in [127:96] .. K3 in [31:0]
//   i_key_en  one-cycle strobe, load i_key
//   i_din     input block, v0 in [63:32], v1 in [31:0]
//   i_din_en  one-cycle strobe, start a block
//   o_dout    result block, same packing as i_din
//   o_dout_en one-cycle strobe, o_dout valid
//   o_key_ok  key loaded, engine may accept blocks
// master = wrapper side, slave = engine side.
interface xtea_crypt_core_if;
  logic         i_flag;
  logic [127:0] i_key;
  logic         i_key_en;
  logic [63:0]  i_din;
  logic         i_din_en;
  logic [63:0]  o_dout;
  logic         o_dout_en;
  logic         o_key_ok;

  modport master (
    output i_flag, i_key, i_key_en, i_din, i_din_en,
    input  o_dout, o_dout_en, o_key_ok
  );

  modport slave (
    input  i_flag, i_key, i_key_en, i_din, i_din_en,
    output o_dout, o_dout_en, o_key_ok
  );
endinterface

// File: rtl/xtea_crypt_core.sv
// Iterative XTEA engine: 64-bit block, 128-bit key, 64 Feistel rounds done as
// 32 iterations of one cycle each (both halves chained per cycle).
//   i_clk  rising-edge clock
//   i_rst  asynchronous active-low reset
//   bus    xtea_crypt_core_if.slave: key/data strobes, result and key status
module xtea_crypt_core (
  input logic              i_clk,
  input logic              i_rst,
  xtea_crypt_core_if.slave bus
);

  localparam logic [31:0] Delta   = 32'h9E3779B9;
  localparam logic [31:0] SumInit = 32'hC6EF3720;  // Delta * 32

  typedef enum logic [1:0] {StNokey, StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [31:0]   v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic          enc_q, enc_d;
  logic [127:0]  key_q, key_d;
  logic [63:0]   dout_q, dout_d;
  logic          dout_en_q, dout_en_d;
  logic          key_ok_q, key_ok_d;

  logic          key_load, accept;
  logic [31:0]   v0_e, v1_e, sum_e, v0_x, v1_x, sum_x, v0_n, v1_n, sum_n;

  function automatic logic [31:0] f_mix(input logic [31:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = k[127:96];
      2'd1:    w = k[95:64];
      2'd2:    w = k[63:32];
      default: w = k[31:0];
    endcase
    return w;
  endfunction

  // One full iteration (two Feistel rounds) in each direction.
  always_comb begin
    v0_e  = v0_q + (f_mix(v1_q) ^ (sum_q + key_word(key_q, sum_q[1:0])));
    sum_e = sum_q + Delta;
    v1_e  = v1_q + (f_mix(v0_e) ^ (sum_e + key_word(key_q, sum_e[12:11])));

    v1_x  = v1_q - (f_mix(v0_q) ^ (sum_q + key_word(key_q, sum_q[12:11])));
    sum_x = sum_q - Delta;
    v0_x  = v0_q - (f_mix(v1_x) ^ (sum_x + key_word(key_q, sum_x[1:0])));

    v0_n  = enc_q ? v0_e  : v0_x;
    v1_n  = enc_q ? v1_e  : v1_x;
    sum_n = enc_q ? sum_e : sum_x;
  end

  // Key load wins over a simultaneous block start; both are ignored while busy.
  assign key_load = bus.i_key_en && (state_q != StBusy);
  assign accept   = bus.i_din_en && !bus.i_key_en && (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    sum_d     = sum_q;
    enc_d     = enc_q;
    dout_d    = dout_q;
    dout_en_d = 1'b0;
    key_d     = key_load ? bus.i_key : key_q;

    // o_key_ok lags the state by one edge: low on the loading edge, high after
    // the next one, while the engine already counts as idle in between.
    key_ok_d = key_ok_q;
    if (key_load) begin
      key_ok_d = 1'b0;
    end else if (state_q != StNokey) begin
      key_ok_d = 1'b1;
    end

    case (state_q)
      StNokey: begin
        if (key_load) state_d = StIdle;
      end
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = 5'd0;
          v0_d    = bus.i_din[63:32];
          v1_d    = bus.i_din[31:0];
          enc_d   = bus.i_flag;
          sum_d   = bus.i_flag ? 32'd0 : SumInit;
        end
      end
      StBusy: begin
        v0_d  = v0_n;
        v1_d  = v1_n;
        sum_d = sum_n;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d   = StIdle;
          dout_d    = {v0_n, v1_n};
          dout_en_d = 1'b1;
        end
      end
      default: state_d = StNokey;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= StNokey;
      cnt_q     <= 5'd0;
      v0_q      <= 32'd0;
      v1_q      <= 32'd0;
      sum_q     <= 32'd0;
      enc_q     <= 1'b0;
      key_q     <= 128'd0;
      dout_q    <= 64'd0;
      dout_en_q <= 1'b0;
      key_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      sum_q     <= sum_d;
      enc_q     <= enc_d;
      key_q     <= key_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      key_ok_q  <= key_ok_d;
    end
  end

  assign bus.o_dout    = dout_q;
  assign bus.o_dout_en = dout_en_q;
  assign bus.o_key_ok  = key_ok_q;

endmodule

// File: tb/tb_xtea_crypt_core.sv
module tb_xtea_crypt_core;

  localparam logic [31:0]  Delta = 32'h9E3779B9;
  localparam logic [127:0] KeyA  = 128'h78695a4b3c2d1e0ff0e1d2c3b4a59687;
  localparam logic [63:0]  PtA   = 64'hf0e1d2c3b4a59687;
  localparam logic [63:0]  CtA   = 64'h704b31344744dfab;
  localparam logic [63:0]  CtZ   = 64'hdee9d4d8f7131ed9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  xtea_crypt_core_if bus ();

  xtea_crypt_core dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Textbook XTEA, key words big-endian.
  function automatic logic [63:0] ref_xtea(input logic [127:0] key, input logic [63:0] blk,
                                           input bit enc);
    logic [31:0] k [4];
    logic [31:0] v0, v1, sum;
    k[0] = key[127:96]; k[1] = key[95:64]; k[2] = key[63:32]; k[3] = key[31:0];
    v0 = blk[63:32];
    v1 = blk[31:0];
    if (enc) begin
      sum = 0;
      for (int i = 0; i < 32; i++) begin
        v0  = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum % 4]));
        sum = sum + Delta;
        v1  = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[(sum / 2048) % 4]));
      end
    end else begin
      sum = Delta * 32;
      for (int i = 0; i < 32; i++) begin
        v1  = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[(sum / 2048) % 4]));
        sum = sum - Delta;
        v0  = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum % 4]));
      end
    end
    return {v0, v1};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    bus.i_key = k;
    bus.i_key_en = 1'b1;
    @(negedge clk);
    bus.i_key_en = 1'b0;
  endtask

  // Returns at the first negedge after the accepting edge.
  task automatic issue_block(input bit enc, input logic [63:0] d);
    @(negedge clk);
    bus.i_flag = enc;
    bus.i_din = d;
    bus.i_din_en = 1'b1;
    @(negedge clk);
    bus.i_din_en = 1'b0;
    bus.i_din = {$urandom, $urandom};
    bus.i_flag = 1'($urandom);
  endtask

  // lat = number of rising edges elapsed since the accepting edge.
  task automatic wait_result(output logic [63:0] got, output int lat, output bit seen);
    seen = 1'b0;
    got = '0;
    lat = 0;
    while (!seen && lat <= 40) begin
      if (bus.o_dout_en) begin
        seen = 1'b1;
        got = bus.o_dout;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic watch_quiet(input int n, output bit quiet);
    quiet = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.o_dout_en) quiet = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (bus.o_dout !== 64'd0 || bus.o_dout_en !== 1'b0 || bus.o_key_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: dout=%h en=%b key_ok=%b, required 0/0/0",
               bus.o_dout, bus.o_dout_en, bus.o_key_ok);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.o_key_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_key_ok: got %b, required 0", bus.o_key_ok);
    end
  endtask

  task automatic test_key_timing();
    logic [63:0] got;
    int lat;
    bit seen;
    @(negedge clk);
    bus.i_key = '0;
    bus.i_key_en = 1'b1;
    @(negedge clk);  // after K0
    bus.i_key_en = 1'b0;
    n_checks++;
    if (bus.o_key_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL key_ok_after_k0: got %b, required 0", bus.o_key_ok);
    end
    bus.i_din = '0;
    bus.i_flag = 1'b1;
    bus.i_din_en = 1'b1;
    @(negedge clk);  // after K1, which also accepted the block
    bus.i_din_en = 1'b0;
    n_checks++;
    if (bus.o_key_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL key_ok_after_k1: got %b, required 1", bus.o_key_ok);
    end
    wait_result(got, lat, seen);
    n_checks++;
    if (!seen || lat != 32 || got !== CtZ) begin
      n_fail++;
      $display("FAIL zero_key_encrypt: seen=%b lat=%0d dout=%h, required lat=32 dout=%h",
               seen, lat, got, CtZ);
    end
    issue_block(1'b0, CtZ);
    wait_result(got, lat, seen);
    n_checks++;
    if (!seen || lat != 32 || got !== 64'd0) begin
      n_fail++;
      $display("FAIL zero_key_decrypt: seen=%b lat=%0d dout=%h, required lat=32 dout=0",
               seen, lat, got);
    end
  endtask

  task automatic test_vectors();
    logic [63:0] got, exp, pt;
    logic [127:0] rk;
    int lat;
    bit seen;
    for (int pass = 0; pass < 8; pass++) begin
      load_key(KeyA);
      issue_block(1'b1, PtA);
      wait_result(got, lat, seen);
      n_checks++;
      if (!seen || got !== CtA) begin
        n_fail++;
        $display("FAIL vector_encrypt[%0d]: seen=%b dout=%h, required %h", pass, seen, got, CtA);
      end
      issue_block(1'b0, CtA);
      wait_result(got, lat, seen);
      n_checks++;
      if (!seen || got !== PtA) begin
        n_fail++;
        $display("FAIL vector_decrypt[%0d]: seen=%b dout=%h, required %h", pass, seen, got, PtA);
      end
      rk = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom};
      load_key(rk);
      for (int d = 0; d < 2; d++) begin
        exp = ref_xtea(rk, pt, d == 0);
        issue_block(d == 0, pt);
        wait_result(got, lat, seen);
        n_checks++;
        if (!seen || lat != 32 || got !== exp) begin
          n_fail++;
          $display("FAIL random_block[%0d.%0d]: seen=%b lat=%0d dout=%h, required %h",
                   pass, d, seen, lat, got, exp);
        end
      end
    end
  endtask

  task automatic test_drop();
    logic [63:0] got, pt, exp;
    logic [127:0] k;
    int lat;
    bit seen, quiet;
    apply_reset();
    issue_block(1'b1, 64'h0123456789abcdef);
    watch_quiet(40, quiet);
    n_checks++;
    if (!quiet || bus.o_dout !== 64'd0) begin
      n_fail++;
      $display("FAIL drop_without_key: quiet=%b dout=%h, required quiet=1 dout=0",
               quiet, bus.o_dout);
    end
    k = {$urandom, $urandom, $urandom, $urandom};
    pt = {$urandom, $urandom};
    exp = ref_xtea(k, pt, 1'b1);
    load_key(k);
    issue_block(1'b1, pt);
    repeat (6) @(negedge clk);
    bus.i_din = ~pt;
    bus.i_flag = 1'b0;
    bus.i_din_en = 1'b1;
    @(negedge clk);
    bus.i_din_en = 1'b0;
    wait_result(got, lat, seen);
    n_checks++;
    if (!seen || got !== exp) begin
      n_fail++;
      $display("FAIL drop_while_busy_result: seen=%b dout=%h, required %h", seen, got, exp);
    end
    watch_quiet(40, quiet);
    n_checks++;
    if (!quiet || bus.o_dout !== exp) begin
      n_fail++;
      $display("FAIL drop_while_busy_extra: quiet=%b dout=%h, required quiet=1 dout=%h",
               quiet, bus.o_dout, exp);
    end
  endtask

  task automatic test_key_busy();
    logic [63:0] got, pt;
    logic [127:0] ka, kb;
    int lat;
    bit seen, quiet;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    pt = {$urandom, $urandom};
    load_key(ka);
    issue_block(1'b1, pt);
    repeat (4) @(negedge clk);
    bus.i_key = kb;
    bus.i_key_en = 1'b1;
    @(negedge clk);
    bus.i_key_en = 1'b0;
    wait_result(got, lat, seen);
    n_checks++;
    if (!seen || got !== ref_xtea(ka, pt, 1'b1) || bus.o_key_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL key_en_busy_result: seen=%b dout=%h key_ok=%b, required %h key_ok=1",
               seen, got, bus.o_key_ok, ref_xtea(ka, pt, 1'b1));
    end
    issue_block(1'b0, pt);
    wait_result(got, lat, seen);
    n_checks++;
    if (!seen || got !== ref_xtea(ka, pt, 1'b0)) begin
      n_fail++;
      $display("FAIL key_en_busy_kept_old: seen=%b dout=%h, required %h",
               seen, got, ref_xtea(ka, pt, 1'b0));
    end
    @(negedge clk);
    bus.i_key = kb;
    bus.i_key_en = 1'b1;
    bus.i_din = pt;
    bus.i_flag = 1'b1;
    bus.i_din_en = 1'b1;
    @(negedge clk);
    bus.i_key_en = 1'b0;
    bus.i_din_en = 1'b0;
    watch_quiet(40, quiet);
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL key_and_din_together: quiet=%b, required 1 (block dropped)", quiet);
    end
    issue_block(1'b1, pt);
    wait_result(got, lat, seen);
    n_checks++;
    if (!seen || got !== ref_xtea(kb, pt, 1'b1)) begin
      n_fail++;
      $display("FAIL key_and_din_new_key: seen=%b dout=%h, required %h",
               seen, got, ref_xtea(kb, pt, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] got, pt;
    logic [127:0] k;
    int lat;
    bit seen, quiet;
    issue_block(1'b1, 64'h1122334455667788);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_dout !== 64'd0 || bus.o_dout_en !== 1'b0 || bus.o_key_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: dout=%h en=%b key_ok=%b, required 0/0/0",
               bus.o_dout, bus.o_dout_en, bus.o_key_ok);
    end
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet(40, quiet);
    n_checks++;
    if (!quiet || bus.o_key_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: quiet=%b key_ok=%b, required quiet=1 key_ok=0",
               quiet, bus.o_key_ok);
    end
    issue_block(1'b1, 64'h1122334455667788);
    watch_quiet(40, quiet);
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL reset_mid_needs_key: quiet=%b, required 1", quiet);
    end
    k = {$urandom, $urandom, $urandom, $urandom};
    pt = {$urandom, $urandom};
    load_key(k);
    issue_block(1'b0, pt);
    wait_result(got, lat, seen);
    n_checks++;
    if (!seen || lat != 32 || got !== ref_xtea(k, pt, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_mid_reload: seen=%b lat=%0d dout=%h, required lat=32 dout=%h",
               seen, lat, got, ref_xtea(k, pt, 1'b0));
    end
  endtask

  // Second strobe sampled at E<second_edge>; E33 is accepted, E32 is not.
  task automatic test_back_to_back();
    logic [63:0] p1, p2, r1, r2;
    logic [127:0] k;
    int n, n1, n2;
    bit bad_width;
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k);
    for (int second_edge = 32; second_edge <= 33; second_edge++) begin
      p1 = {$urandom, $urandom};
      p2 = {$urandom, $urandom};
      r1 = ref_xtea(k, p1, 1'b1);
      r2 = ref_xtea(k, p2, 1'b0);
      issue_block(1'b1, p1);
      n = 0;
      n1 = -1;
      n2 = -1;
      bad_width = 1'b0;
      while (n <= 80) begin
        if (bus.o_dout_en) begin
          if (n1 < 0) begin
            n1 = n;
            if (bus.o_dout !== r1) bad_width = 1'b1;
          end else if (n2 < 0) begin
            n2 = n;
            if (bus.o_dout !== r2) bad_width = 1'b1;
          end
        end
        if (n == 33 && bus.o_dout_en) bad_width = 1'b1;
        if (n == 50 && bus.o_dout !== r1) bad_width = 1'b1;
        bus.i_din_en = (n == second_edge - 1);
        bus.i_din = p2;
        bus.i_flag = 1'b0;
        @(negedge clk);
        n++;
      end
      bus.i_din_en = 1'b0;
      n_checks++;
      if (second_edge == 33) begin
        if (n1 != 32 || n2 != 65 || bad_width) begin
          n_fail++;
          $display("FAIL back_to_back_e33: first=%0d second=%0d bad=%b, required 32/65/0",
                   n1, n2, bad_width);
        end
      end else begin
        if (n1 != 32 || n2 != -1 || bad_width) begin
          n_fail++;
          $display("FAIL strobe_at_e32_ignored: first=%0d second=%0d bad=%b, required 32/-1/0",
                   n1, n2, bad_width);
        end
      end
    end
  endtask

  initial begin
    bus.i_flag = 1'b0;
    bus.i_key = '0;
    bus.i_key_en = 1'b0;
    bus.i_din = '0;
    bus.i_din_en = 1'b0;
    test_reset();
    test_key_timing();
    test_vectors();
    test_drop();
    test_key_busy();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
